// File: rtl/of_hazard_ctrl_pkg.sv
// Shared types for the operand-fetch interlock: opcode classes, FSM states,
// and the shadow-scoreboard slot layout.
package of_hazard_ctrl_pkg;

  localparam int         REG_W     = 4;
  localparam logic [3:0] REG_RA    = 4'd15;
  localparam int         NUM_SLOTS = 3;
  localparam int         SLOT_EX   = 0;
  localparam int         SLOT_MA   = 1;
  localparam int         SLOT_RW   = 2;

  typedef enum logic [1:0] {
    OPC_ALU    = 2'd0,
    OPC_LD     = 2'd1,
    OPC_MUL    = 2'd2,
    OPC_DIVMOD = 2'd3
  } op_class_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb;
    logic             ld;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;

  // mul/div take priority because they decide EX occupancy.
  function automatic op_class_e op_class(input logic ld, input logic mul, input logic divmod);
    if (mul)         return OPC_MUL;
    else if (divmod) return OPC_DIVMOD;
    else if (ld)     return OPC_LD;
    else             return OPC_ALU;
  endfunction

endpackage

// File: rtl/of_hazard_ctrl_if.sv
// OF-stage instruction fields in, pipeline control out. The master drives the
// decoded OF instruction; the slave is the interlock controller.
interface of_hazard_ctrl_if;
  import of_hazard_ctrl_pkg::*;

  logic             of_valid;
  logic [REG_W-1:0] of_src1;
  logic [REG_W-1:0] of_src2;
  logic             of_src1_used;
  logic             of_src2_used;
  logic [REG_W-1:0] of_dest;
  logic             of_wb;
  logic             of_ld;
  logic             of_mul;
  logic             of_divmod;
  logic             ex_branch_taken;
  logic             stall_if;
  logic             stall_of;
  logic             bubble_ex;
  logic             flush;
  logic             ex_hold;
  logic [31:0]      stall_count;

  modport master (
    output of_valid, of_src1, of_src2, of_src1_used, of_src2_used, of_dest,
           of_wb, of_ld, of_mul, of_divmod, ex_branch_taken,
    input  stall_if, stall_of, bubble_ex, flush, ex_hold, stall_count
  );

  modport slave (
    input  of_valid, of_src1, of_src2, of_src1_used, of_src2_used, of_dest,
           of_wb, of_ld, of_mul, of_divmod, ex_branch_taken,
    output stall_if, stall_of, bubble_ex, flush, ex_hold, stall_count
  );

endinterface

// File: rtl/of_hazard_ctrl_cmp.sv
// One shadow slot compared against both OF source operands.
module of_hazard_cmp
  import of_hazard_ctrl_pkg::*;
#(
  parameter bit EN      = 1'b1,
  parameter bit LD_ONLY = 1'b0
) (
  input  slot_t            slot,
  input  logic             of_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             src1_used,
  input  logic             src2_used,
  output logic             match
);

  logic writer;
  logic hit1;
  logic hit2;

  // With forwarding only a load still in EX cannot be bypassed.
  assign writer = EN & of_valid & slot.valid & slot.wb & (slot.ld | ~LD_ONLY);
  assign hit1   = src1_used & (slot.dest == src1);
  assign hit2   = src2_used & (slot.dest == src2);
  assign match  = writer & (hit1 | hit2);

endmodule

// File: rtl/of_hazard_ctrl.sv
// RAW interlock and multi-cycle EX sequencer around the operand-fetch stage.
// Control outputs are combinational from OF inputs and registered state.
module of_hazard_ctrl
  import of_hazard_ctrl_pkg::*;
#(
  parameter int FWD     = 0,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              reset,
  of_hazard_ctrl_if.slave   bus
);

  // Sized for the longer op so a MUL_LAT above DIV_LAT cannot wrap.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  slot_t [NUM_SLOTS-1:0]   slot_q, slot_d;
  logic [31:0]             stall_count_q, stall_count_d;

  logic [NUM_SLOTS-1:0]    match;
  logic                    hazard;
  slot_t                   of_slot;
  logic                    stall_c;
  logic                    bubble_c;
  logic                    flush_c;
  logic                    hold_c;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_cmp
    of_hazard_cmp #(
      .EN      (FWD == 0 || i == SLOT_EX),
      .LD_ONLY (FWD != 0 && i == SLOT_EX)
    ) u_cmp (
      .slot      (slot_q[i]),
      .of_valid  (bus.of_valid),
      .src1      (bus.of_src1),
      .src2      (bus.of_src2),
      .src1_used (bus.of_src1_used),
      .src2_used (bus.of_src2_used),
      .match     (match[i])
    );
  end

  assign hazard = |match;

  always_comb begin
    of_slot       = '{valid: bus.of_valid, dest: bus.of_dest, wb: bus.of_wb, ld: bus.of_ld};
    state_d       = state_q;
    cnt_d         = cnt_q;
    slot_d        = slot_q;
    stall_c       = 1'b0;
    bubble_c      = 1'b0;
    flush_c       = 1'b0;
    hold_c        = 1'b0;
    stall_count_d = stall_count_q;

    case (state_q)
      ST_RUN: begin
        // A taken branch squashes OF, so a hazard on that instruction is moot.
        if (bus.ex_branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (hazard) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
        slot_d[SLOT_EX] = bubble_c ? SLOT_NONE : of_slot;
        slot_d[SLOT_MA] = slot_q[SLOT_EX];
        slot_d[SLOT_RW] = slot_q[SLOT_MA];
        if (bus.of_valid && !bubble_c) begin
          case (op_class(bus.of_ld, bus.of_mul, bus.of_divmod))
            OPC_MUL: if (MUL_LAT > 1) begin
              cnt_d   = MUL_CNT;
              state_d = ST_MULTI;
            end
            OPC_DIVMOD: if (DIV_LAT > 1) begin
              cnt_d   = DIV_CNT;
              state_d = ST_MULTI;
            end
            default: ;
          endcase
        end
      end
      ST_MULTI: begin
        hold_c  = 1'b1;
        stall_c = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        // EX keeps the long op; MA sees bubbles until the final cycle.
        slot_d[SLOT_MA] = (cnt_q == CNT_W'(1)) ? slot_q[SLOT_EX] : SLOT_NONE;
        slot_d[SLOT_RW] = slot_q[SLOT_MA];
        if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (stall_c && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      slot_q        <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_if    = ~reset & stall_c;
  assign bus.stall_of    = ~reset & stall_c;
  assign bus.bubble_ex   = ~reset & bubble_c;
  assign bus.flush       = ~reset & flush_c;
  assign bus.ex_hold     = ~reset & hold_c;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_of_hazard_ctrl.sv
// Directed bench for of_hazard_ctrl: FWD=0 (MUL_LAT=3) and FWD=1 (MUL_LAT=1)
// instances receive identical stimulus; each has its own expected values.
module tb_of_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       u2;
    logic [3:0] d;
    logic       wb;
    logic       ld;
    logic       mul;
    logic       dm;
  } instr_t;

  typedef struct {
    string  name;
    instr_t pre;
    instr_t cur;
    logic   br;
    logic   st0;
    logic   st1;
  } vec_t;

  localparam int NV = 14;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  of_hazard_ctrl_if if0 ();
  of_hazard_ctrl_if if1 ();

  of_hazard_ctrl #(.FWD(0), .MUL_LAT(3), .DIV_LAT(8)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  of_hazard_ctrl #(.FWD(1), .MUL_LAT(1), .DIV_LAT(8)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  function automatic instr_t f_alu(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    instr_t x = '0;
    x.v = 1; x.d = d; x.s1 = s1; x.s2 = s2; x.u1 = 1; x.u2 = 1; x.wb = 1;
    return x;
  endfunction

  function automatic instr_t f_imm(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    instr_t x = f_alu(d, s1, s2);
    x.u2 = 0;
    return x;
  endfunction

  function automatic instr_t f_ld(input logic [3:0] d, input logic [3:0] s1);
    instr_t x = f_imm(d, s1, 4'd0);
    x.ld = 1;
    return x;
  endfunction

  function automatic instr_t f_st(input logic [3:0] rd, input logic [3:0] s1);
    instr_t x = f_alu(rd, s1, rd);
    x.wb = 0;
    return x;
  endfunction

  function automatic instr_t f_div(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    instr_t x = f_alu(d, s1, s2);
    x.dm = 1;
    return x;
  endfunction

  function automatic instr_t f_mul(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    instr_t x = f_alu(d, s1, s2);
    x.mul = 1;
    return x;
  endfunction

  function automatic instr_t f_inv(input instr_t i);
    instr_t x = i;
    x.v = 0;
    return x;
  endfunction

  task automatic drive(input instr_t x, input logic br);
    if0.of_valid = x.v;  if0.of_src1 = x.s1; if0.of_src2 = x.s2;
    if0.of_src1_used = x.u1; if0.of_src2_used = x.u2; if0.of_dest = x.d;
    if0.of_wb = x.wb; if0.of_ld = x.ld; if0.of_mul = x.mul; if0.of_divmod = x.dm;
    if0.ex_branch_taken = br;
    if1.of_valid = x.v;  if1.of_src1 = x.s1; if1.of_src2 = x.s2;
    if1.of_src1_used = x.u1; if1.of_src2_used = x.u2; if1.of_dest = x.d;
    if1.of_wb = x.wb; if1.of_ld = x.ld; if1.of_mul = x.mul; if1.of_divmod = x.dm;
    if1.ex_branch_taken = br;
  endtask

  function automatic logic [31:0] o0();
    return {27'd0, if0.ex_hold, if0.flush, if0.bubble_ex, if0.stall_of, if0.stall_if};
  endfunction

  function automatic logic [31:0] o1();
    return {27'd0, if1.ex_hold, if1.flush, if1.bubble_ex, if1.stall_of, if1.stall_if};
  endfunction

  // {ex_hold, flush, bubble_ex, stall_of, stall_if}
  function automatic logic [31:0] pk(input logic hold, input logic fl, input logic bub, input logic st);
    return {27'd0, hold, fl, bub, st, st};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    instr_t call_i, ret_i, movi;
    call_i = '0; call_i.v = 1; call_i.d = 4'd15; call_i.wb = 1;
    ret_i  = '0; ret_i.v = 1; ret_i.s1 = 4'd15; ret_i.u1 = 1;
    movi   = '0; movi.v = 1; movi.s1 = 4'd4; movi.d = 4'd9; movi.wb = 1;

    vecs[0]  = '{"raw_ex",      f_alu(4,1,2),        f_alu(5,4,1),         0, 1, 0};
    vecs[1]  = '{"ld_use_s1",   f_ld(2,1),           f_alu(5,2,3),         0, 1, 1};
    vecs[2]  = '{"ld_use_s2",   f_ld(3,1),           f_alu(5,1,3),         0, 1, 1};
    vecs[3]  = '{"imm_no_s2",   f_alu(6,1,2),        f_imm(7,1,6),         0, 0, 0};
    vecs[4]  = '{"st_rd_alu",   f_alu(7,1,2),        f_st(7,1),            0, 1, 0};
    vecs[5]  = '{"st_rd_ld",    f_ld(7,1),           f_st(7,2),            0, 1, 1};
    vecs[6]  = '{"pre_no_wb",   f_st(8,1),           f_alu(5,8,9),         0, 0, 0};
    vecs[7]  = '{"of_invalid",  f_alu(4,1,2),        f_inv(f_alu(5,4,1)),  0, 0, 0};
    vecs[8]  = '{"pre_invalid", f_inv(f_alu(4,1,2)), f_alu(5,4,1),         0, 0, 0};
    vecs[9]  = '{"br_hazard",   f_ld(2,1),           f_alu(5,2,3),         1, 0, 0};
    vecs[10] = '{"br_clean",    f_alu(4,1,2),        f_alu(5,9,10),        1, 0, 0};
    vecs[11] = '{"no_match",    f_ld(4,1),           f_alu(5,6,7),         0, 0, 0};
    vecs[12] = '{"ret_ra",      call_i,              ret_i,                0, 1, 0};
    vecs[13] = '{"s1_unused",   f_ld(4,1),           movi,                 0, 0, 0};

    // Outputs are forced low while reset is held, even with live inputs.
    reset = 1'b1;
    drive(f_alu(5,4,1), 1'b1);
    #2;
    chk("reset_out_f0", o0(), 32'd0);
    chk("reset_out_f1", o1(), 32'd0);
    chk("reset_cnt_f0", if0.stall_count, 32'd0);
    chk("reset_cnt_f1", if1.stall_count, 32'd0);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      drive(vecs[i].pre, 1'b0);
      tick();
      drive(vecs[i].cur, vecs[i].br);
      @(negedge clk);
      chk({vecs[i].name, "_f0"}, o0(), pk(0, vecs[i].br, vecs[i].br | vecs[i].st0, vecs[i].st0));
      chk({vecs[i].name, "_f1"}, o1(), pk(0, vecs[i].br, vecs[i].br | vecs[i].st1, vecs[i].st1));
    end

    // RAW against EX/MA/RW without forwarding: three stall cycles.
    do_reset();
    drive(f_alu(4,1,2), 1'b0);
    tick();
    drive(f_alu(5,4,1), 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("raw_seq%0d_f0", c), o0(), pk(0, 0, c < 3, c < 3));
      chk($sformatf("raw_seq%0d_f1", c), o1(), pk(0, 0, 0, 0));
      tick();
    end
    chk("raw_cnt_f0", if0.stall_count, 32'd3);
    chk("raw_cnt_f1", if1.stall_count, 32'd0);

    // div occupies EX: 7 hold cycles, branch ignored while holding.
    do_reset();
    drive(f_div(3,1,2), 1'b0);
    @(negedge clk);
    chk("div_issue_f0", o0(), 32'd0);
    tick();
    for (int m = 0; m < 7; m++) begin
      drive(f_alu(6,3,4), m == 3);
      @(negedge clk);
      chk($sformatf("div_hold%0d_f0", m), o0(), pk(1, 0, 0, 1));
      chk($sformatf("div_hold%0d_f1", m), o1(), pk(1, 0, 0, 1));
      tick();
    end
    drive(f_alu(6,3,4), 1'b0);
    chk("div_cnt7_f0", if0.stall_count, 32'd7);
    chk("div_cnt7_f1", if1.stall_count, 32'd7);
    // Without forwarding the div dest is seen in EX+MA, MA+RW, then RW.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk($sformatf("div_after%0d_f0", r), o0(), pk(0, 0, r < 3, r < 3));
      chk($sformatf("div_after%0d_f1", r), o1(), pk(0, 0, 0, 0));
      tick();
    end
    chk("div_cnt_end_f0", if0.stall_count, 32'd10);
    chk("div_cnt_end_f1", if1.stall_count, 32'd7);

    // mul: MUL_LAT=3 holds 2 cycles, MUL_LAT=1 never holds.
    do_reset();
    drive(f_mul(5,1,2), 1'b0);
    tick();
    drive(f_alu(9,10,11), 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mul%0d_f0", c), o0(), (c < 2) ? pk(1, 0, 0, 1) : 32'd0);
      chk($sformatf("mul%0d_f1", c), o1(), 32'd0);
      tick();
    end

    // Reset asserted with the div counter at 4.
    do_reset();
    drive(f_div(3,1,2), 1'b0);
    tick();
    drive(f_alu(6,3,4), 1'b1);
    repeat (3) tick();
    chk("mid_multi_f0", o0(), pk(1, 0, 0, 1));
    reset = 1'b1;
    #1;
    chk("async_rst_f0", o0(), 32'd0);
    chk("async_rst_f1", o1(), 32'd0);
    chk("async_rst_cnt_f0", if0.stall_count, 32'd0);
    tick();
    reset = 1'b0;
    drive(f_alu(6,3,4), 1'b0);
    @(negedge clk);
    chk("post_rst_f0", o0(), 32'd0);
    chk("post_rst_f1", o1(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
